// File: rtl/ara_pkg.sv
// ----------------------------------------------------------------------------
// ara_pkg: shared queue enumeration and scheduler types.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ara_pkg;

  localparam int unsigned NrOperandQueues = 9;
  localparam int unsigned SchedLenWidth   = 16;

  typedef enum logic [3:0] {
    AluA,
    AluB,
    AluC,
    MulFPUA,
    MulFPUB,
    MulFPUC,
    MaskB,
    MaskM,
    SlideAddrGenA
  } opqueue_e;

  typedef logic [SchedLenWidth-1:0] sched_len_t;

  typedef enum logic [0:0] {
    QIdle   = 1'b0,
    QActive = 1'b1
  } sched_state_e;

endpackage

`default_nettype wire

// File: rtl/opq_credit_counter.sv
// ----------------------------------------------------------------------------
// opq_credit_counter: per-queue buffer credit, saturating at Depth.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module opq_credit_counter
  import ara_pkg::*;
#(
  parameter int unsigned Depth = 5
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic nonzero_o
);

  localparam int unsigned CreditWidth = $clog2(Depth + 1);
  localparam logic [CreditWidth-1:0] CreditMax = CreditWidth'(Depth);

  logic [CreditWidth-1:0] credit_q, credit_d;

  always_comb begin
    credit_d = credit_q;
    if (inc_i && !dec_i) begin
      if (credit_q != CreditMax) credit_d = credit_q + CreditWidth'(1);
    end else if (dec_i && !inc_i) begin
      if (credit_q != '0) credit_d = credit_q - CreditWidth'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) credit_q <= CreditMax;
    else       credit_q <= credit_d;
  end

  assign nonzero_o = (credit_q != '0);

  // A pop returned while the queue already holds every credit means the queue broke protocol.
  always @(posedge clk_i) begin
    if (!rst_i) assert (!(inc_i && !dec_i && (credit_q == CreditMax)));
  end

endmodule

`default_nettype wire

// File: rtl/operand_queue_read_scheduler.sv
// ----------------------------------------------------------------------------
// operand_queue_read_scheduler: round-robin, credit-gated VRF read sharing.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module operand_queue_read_scheduler
  import ara_pkg::*;
#(
  parameter  int unsigned NrQueues = NrOperandQueues,
  parameter  int unsigned Depth    = 5,
  parameter  int unsigned LenWidth = SchedLenWidth,
  localparam int unsigned IdxWidth = (NrQueues > 1) ? $clog2(NrQueues) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NrQueues-1:0]          req_valid_i,
  input  logic [NrQueues*LenWidth-1:0] req_len_i,
  output logic [NrQueues-1:0]          req_ready_o,
  output logic                         vrf_req_valid_o,
  output logic [IdxWidth-1:0]          vrf_req_queue_o,
  input  logic                         vrf_req_ready_i,
  output logic [NrQueues-1:0]          operand_issued_o,
  input  logic [NrQueues-1:0]          operand_consumed_i,
  output logic [NrQueues-1:0]          burst_done_o
);

  localparam int unsigned SumWidth = IdxWidth + 1;
  localparam logic [SumWidth-1:0] NrQ     = SumWidth'(NrQueues);
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NrQueues - 1);

  sched_state_e        state_q     [NrQueues];
  sched_state_e        state_d     [NrQueues];
  logic [LenWidth-1:0] remaining_q [NrQueues];
  logic [LenWidth-1:0] remaining_d [NrQueues];
  logic [IdxWidth-1:0] rr_ptr_q, rr_ptr_d;
  logic [NrQueues-1:0] done_q, done_d;

  logic [NrQueues-1:0] credit_nz, eligible, rotated, issued;
  logic [IdxWidth-1:0] grant;
  logic                found;
  logic                handshake;

  // Both operands are below NrQueues, so one conditional subtraction wraps the sum.
  function automatic logic [IdxWidth-1:0] wrap_add(input logic [IdxWidth-1:0] a,
                                                   input logic [IdxWidth-1:0] b);
    logic [SumWidth-1:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= NrQ) s = s - NrQ;
    return s[IdxWidth-1:0];
  endfunction

  always_comb begin
    for (int q = 0; q < NrQueues; q++) begin
      eligible[q]    = (state_q[q] == QActive) && credit_nz[q];
      req_ready_o[q] = (state_q[q] == QIdle);
    end
  end

  always_comb begin
    rotated = '0;
    grant   = '0;
    found   = 1'b0;
    for (int i = 0; i < NrQueues; i++) begin
      rotated[i] = eligible[wrap_add(rr_ptr_q, IdxWidth'(i))];
    end
    for (int i = 0; i < NrQueues; i++) begin
      if (rotated[i] && !found) begin
        found = 1'b1;
        grant = wrap_add(rr_ptr_q, IdxWidth'(i));
      end
    end
  end

  assign vrf_req_valid_o = |eligible;
  assign vrf_req_queue_o = grant;
  assign handshake       = vrf_req_valid_o && vrf_req_ready_i;

  always_comb begin
    for (int q = 0; q < NrQueues; q++) begin
      issued[q] = handshake && (grant == IdxWidth'(q));
    end
  end

  assign operand_issued_o = issued;
  assign burst_done_o     = done_q;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    done_d   = '0;
    for (int q = 0; q < NrQueues; q++) begin
      state_d[q]     = state_q[q];
      remaining_d[q] = remaining_q[q];
      case (state_q[q])
        QIdle: begin
          if (req_valid_i[q]) begin
            if (req_len_i[q*LenWidth +: LenWidth] == '0) begin
              done_d[q] = 1'b1;
            end else begin
              state_d[q]     = QActive;
              remaining_d[q] = req_len_i[q*LenWidth +: LenWidth];
            end
          end
        end
        QActive: begin
          if (issued[q]) begin
            remaining_d[q] = remaining_q[q] - LenWidth'(1);
            if (remaining_q[q] == LenWidth'(1)) begin
              state_d[q] = QIdle;
              done_d[q]  = 1'b1;
            end
          end
        end
        default: state_d[q] = QIdle;
      endcase
    end
    if (handshake) rr_ptr_d = (grant == LastIdx) ? '0 : grant + IdxWidth'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int q = 0; q < NrQueues; q++) begin
        state_q[q]     <= QIdle;
        remaining_q[q] <= '0;
      end
      rr_ptr_q <= '0;
      done_q   <= '0;
    end else begin
      for (int q = 0; q < NrQueues; q++) begin
        state_q[q]     <= state_d[q];
        remaining_q[q] <= remaining_d[q];
      end
      rr_ptr_q <= rr_ptr_d;
      done_q   <= done_d;
    end
  end

  for (genvar q = 0; q < NrQueues; q++) begin : g_credit
    opq_credit_counter #(
      .Depth(Depth)
    ) i_credit (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .inc_i    (operand_consumed_i[q]),
      .dec_i    (issued[q]),
      .nonzero_o(credit_nz[q])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_operand_queue_read_scheduler.sv
// ----------------------------------------------------------------------------
// tb_operand_queue_read_scheduler: table, directed and random checks.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_operand_queue_read_scheduler;

  localparam int N     = 9;
  localparam int LW    = 16;
  localparam int DEPTH = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*LW-1:0] req_len   = '0;
  logic [N-1:0]    req_ready;
  logic            vrf_valid;
  logic [3:0]      vrf_queue;
  logic            vrf_ready = 1'b0;
  logic [N-1:0]    issued;
  logic [N-1:0]    consumed  = '0;
  logic [N-1:0]    done;

  always #5 clk = ~clk;

  operand_queue_read_scheduler #(
    .NrQueues(N), .Depth(DEPTH), .LenWidth(LW)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .req_valid_i       (req_valid),
    .req_len_i         (req_len),
    .req_ready_o       (req_ready),
    .vrf_req_valid_o   (vrf_valid),
    .vrf_req_queue_o   (vrf_queue),
    .vrf_req_ready_i   (vrf_ready),
    .operand_issued_o  (issued),
    .operand_consumed_i(consumed),
    .burst_done_o      (done)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: words left, credits held, round-robin pointer, pending done pulses.
  bit           m_active [N];
  int           m_rem    [N];
  int           m_credit [N];
  int           m_rr;
  logic [N-1:0] m_done;

  logic [N-1:0] a_ready, a_issued, a_done;
  logic         a_valid;
  logic [3:0]   a_q;

  typedef struct {
    logic [N-1:0] rv;
    int           len;
    logic         vr;
    logic [N-1:0] cons;
    logic [N-1:0] e_ready;
    logic         e_valid;
    logic [3:0]   e_q;
    logic [N-1:0] e_issued;
    logic [N-1:0] e_done;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int q = 0; q < N; q++) begin
      m_active[q] = 1'b0;
      m_rem[q]    = 0;
      m_credit[q] = DEPTH;
    end
    m_rr   = 0;
    m_done = '0;
  endtask

  function automatic logic [N*LW-1:0] lens_all(input int len);
    logic [N*LW-1:0] v;
    for (int q = 0; q < N; q++) v[q*LW +: LW] = LW'(len);
    return v;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int q = 0; q < N; q++) if (v[q]) return q;
    return 99;
  endfunction

  // One cycle: drive at the falling edge, compare against the model, advance the model at the rising edge.
  task automatic drive(input logic [N-1:0] rv, input logic [N*LW-1:0] lens,
                       input logic vr, input logic [N-1:0] cons);
    logic [N-1:0] cl, e_ready, e_iss, nd;
    bit           e_valid;
    int           g, qq;
    @(negedge clk);
    cl = '0;
    for (int q = 0; q < N; q++) cl[q] = cons[q] && (m_credit[q] < DEPTH);
    req_valid = rv;
    req_len   = lens;
    vrf_ready = vr;
    consumed  = cl;
    #1;
    e_valid = 1'b0;
    g       = 0;
    for (int i = 0; i < N; i++) begin
      qq = (m_rr + i) % N;
      if (!e_valid && m_active[qq] && m_credit[qq] > 0) begin
        e_valid = 1'b1;
        g       = qq;
      end
    end
    for (int q = 0; q < N; q++) e_ready[q] = !m_active[q];
    e_iss = (e_valid && vr) ? (N'(1) << g) : '0;
    a_ready  = req_ready;
    a_valid  = vrf_valid;
    a_q      = vrf_queue;
    a_issued = issued;
    a_done   = done;
    chk("req_ready", a_ready, e_ready);
    chk("vrf_valid", a_valid, e_valid);
    if (e_valid) chk("vrf_queue", a_q, g);
    chk("issued", a_issued, e_iss);
    chk("burst_done", a_done, m_done);
    @(posedge clk);
    nd = '0;
    if (e_valid && vr) begin
      m_rem[g]--;
      m_credit[g]--;
      if (m_rem[g] == 0) begin
        m_active[g] = 1'b0;
        nd[g]       = 1'b1;
      end
      m_rr = (g + 1) % N;
    end
    for (int q = 0; q < N; q++) begin
      if (e_ready[q] && rv[q]) begin
        if (lens[q*LW +: LW] == '0) nd[q] = 1'b1;
        else begin
          m_active[q] = 1'b1;
          m_rem[q]    = int'(lens[q*LW +: LW]);
        end
      end
      if (cl[q]) m_credit[q]++;
    end
    m_done = nd;
  endtask

  task automatic drain(input int n);
    repeat (n) drive('0, '0, 1'b1, '1);
  endtask

  int cnt;
  int order [3];
  logic [N-1:0] rv_r;
  logic [N*LW-1:0] lens_r;

  initial begin
    // Queue 0 burst of 3, then a len=0 command on queue 5, then credits returned to queue 0.
    tbl[0] = '{9'h001, 3, 1'b1, 9'h000, 9'h1FF, 1'b0, 4'd0, 9'h000, 9'h000};
    tbl[1] = '{9'h000, 0, 1'b1, 9'h000, 9'h1FE, 1'b1, 4'd0, 9'h001, 9'h000};
    tbl[2] = '{9'h000, 0, 1'b1, 9'h000, 9'h1FE, 1'b1, 4'd0, 9'h001, 9'h000};
    tbl[3] = '{9'h000, 0, 1'b1, 9'h000, 9'h1FE, 1'b1, 4'd0, 9'h001, 9'h000};
    tbl[4] = '{9'h020, 0, 1'b1, 9'h000, 9'h1FF, 1'b0, 4'd0, 9'h000, 9'h001};
    tbl[5] = '{9'h000, 0, 1'b1, 9'h001, 9'h1FF, 1'b0, 4'd0, 9'h000, 9'h020};
    tbl[6] = '{9'h000, 0, 1'b1, 9'h001, 9'h1FF, 1'b0, 4'd0, 9'h000, 9'h000};
    tbl[7] = '{9'h000, 0, 1'b1, 9'h001, 9'h1FF, 1'b0, 4'd0, 9'h000, 9'h000};
    order = '{1, 4, 8};

    model_reset();
    @(negedge clk);
    #1;
    chk("rst_ready", req_ready, 9'h1FF);
    chk("rst_valid", vrf_valid, 1'b0);
    chk("rst_queue", vrf_queue, 4'd0);
    chk("rst_issued", issued, 9'h000);
    chk("rst_done", done, 9'h000);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].rv, lens_all(tbl[i].len), tbl[i].vr, tbl[i].cons);
      chk("tbl_ready", a_ready, tbl[i].e_ready);
      chk("tbl_valid", a_valid, tbl[i].e_valid);
      if (tbl[i].e_valid) chk("tbl_queue", a_q, tbl[i].e_q);
      chk("tbl_issued", a_issued, tbl[i].e_issued);
      chk("tbl_done", a_done, tbl[i].e_done);
    end

    // Fairness: three queues interleave strictly in index order with wrap.
    drive(9'h112, lens_all(4), 1'b1, '0);
    for (int k = 0; k < 12; k++) begin
      drive('0, '0, 1'b1, '1);
      chk("fair_order", onehot_idx(a_issued), order[k % 3]);
    end
    drain(6);

    // Backpressure: grant presented but nothing issues while the VRF stalls.
    drive(9'h040, lens_all(3), 1'b1, '0);
    for (int k = 0; k < 4; k++) begin
      drive('0, '0, 1'b0, '0);
      chk("bp_valid", a_valid, 1'b1);
      chk("bp_issued", a_issued, 9'h000);
    end
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      drive('0, '0, 1'b1, '0);
      if (a_issued[6]) cnt++;
    end
    chk("bp_resume", cnt, 3);
    drain(6);

    // Credit stall: only Depth words go out without consumes.
    drive(9'h004, lens_all(8), 1'b1, '0);
    cnt = 0;
    for (int k = 0; k < 7; k++) begin
      drive('0, '0, 1'b1, '0);
      if (a_issued[2]) cnt++;
    end
    chk("stall_count", cnt, 5);
    chk("stall_valid", a_valid, 1'b0);
    drive('0, '0, 1'b1, 9'h004);
    drive('0, '0, 1'b1, '0);
    chk("stall_refill", a_issued[2], 1'b1);
    drain(8);

    // Issue and consume together every cycle keep one queue streaming at full rate.
    drive(9'h080, lens_all(10), 1'b1, '0);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      drive('0, '0, 1'b1, 9'h080);
      if (a_issued[7]) cnt++;
    end
    chk("stream_count", cnt, 10);
    drain(6);

    // Asynchronous reset mid-burst with remaining=6, credit=1.
    drive(9'h008, lens_all(10), 1'b1, '0);
    for (int k = 0; k < 4; k++) drive('0, '0, 1'b1, '0);
    @(negedge clk);
    req_valid = '0;
    vrf_ready = 1'b1;
    consumed  = '0;
    #1;
    chk("pre_rst_valid", vrf_valid, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_ready", req_ready, 9'h1FF);
    chk("arst_valid", vrf_valid, 1'b0);
    chk("arst_queue", vrf_queue, 4'd0);
    chk("arst_issued", issued, 9'h000);
    chk("arst_done", done, 9'h000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    drive(9'h008, lens_all(6), 1'b1, '0);
    cnt = 0;
    for (int k = 0; k < 7; k++) begin
      drive('0, '0, 1'b1, '0);
      if (a_issued[3]) cnt++;
    end
    chk("post_rst_credit", cnt, 5);
    drain(6);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      for (int q = 0; q < N; q++) begin
        rv_r[q] = ($urandom_range(0, 3) == 0);
        lens_r[q*LW +: LW] = LW'($urandom_range(0, 6));
      end
      drive(rv_r, lens_r, ($urandom_range(0, 3) != 0), N'($urandom));
    end
    drain(30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
